output_conditioner: RTL and testbench

//   Drive-side counterpart of the input conditioner. It turns single-cycle raise/lower

---
 rtl/output_conditioner.sv | 118 +++++++++++
 tb/tb_output_conditioner.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/output_conditioner.sv
// Conditions single-cycle raise/lower requests into a registered output pin that holds
// each level for at least holdtime cycles; edges and discarded requests pulse for 1 clk.
module output_conditioner #(
    parameter int unsigned counterwidth = 3,
    parameter int unsigned holdtime     = 3,
    parameter logic        resetlevel   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raise,
    input  logic lower,
    output logic pin,
    output logic busy,
    output logic positiveedge,
    output logic negativeedge,
    output logic dropped
);

    typedef enum logic {StSteady, StHold} state_e;

    localparam logic [counterwidth-1:0] HoldLast = counterwidth'(holdtime - 1);

    state_e                  r_state, w_state_next;
    logic [counterwidth-1:0] r_count, w_count_next;
    logic                    r_pend_valid, w_pend_valid_next;
    logic                    r_pend_level, w_pend_level_next;
    logic                    r_pin, w_pin_next;
    logic                    r_pos, w_pos_next;
    logic                    r_neg, w_neg_next;
    logic                    r_drop, w_drop_next;

    logic w_req, w_target, w_expired, w_go, w_eff_level;

    assign w_req     = raise ^ lower;
    assign w_target  = raise;
    assign w_expired = (r_count == HoldLast);

    always_comb begin
        w_state_next      = r_state;
        w_count_next      = r_count;
        w_pend_valid_next = r_pend_valid;
        w_pend_level_next = r_pend_level;
        w_pin_next        = r_pin;
        w_pos_next        = 1'b0;
        w_neg_next        = 1'b0;
        w_drop_next       = raise & lower;
        w_go              = 1'b0;
        w_eff_level       = w_target;

        unique case (r_state)
            StSteady: begin
                w_go = w_req && (w_target != r_pin);
            end
            StHold: begin
                if (!w_expired) begin
                    w_count_next = r_count + 1'b1;
                    if (w_req) begin
                        if (r_pend_valid && (r_pend_level != w_target)) begin
                            w_drop_next = 1'b1;
                        end
                        w_pend_valid_next = 1'b1;
                        w_pend_level_next = w_target;
                    end
                end else begin
                    // Expiry: a same-cycle request beats the pending one.
                    w_pend_valid_next = 1'b0;
                    w_eff_level       = w_req ? w_target : r_pend_level;
                    if (w_req && r_pend_valid && (r_pend_level != w_target)) begin
                        w_drop_next = 1'b1;
                    end
                    w_go = (w_req || r_pend_valid) && (w_eff_level != r_pin);
                    if (!w_go) begin
                        w_state_next = StSteady;
                        w_count_next = '0;
                    end
                end
            end
            default: w_state_next = StSteady;
        endcase

        if (w_go) begin
            w_pin_next   = w_eff_level;
            w_pos_next   = w_eff_level;
            w_neg_next   = ~w_eff_level;
            w_count_next = '0;
            w_state_next = StHold;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StSteady;
            r_count      <= '0;
            r_pend_valid <= 1'b0;
            r_pend_level <= 1'b0;
            r_pin        <= resetlevel;
            r_pos        <= 1'b0;
            r_neg        <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_pend_valid <= w_pend_valid_next;
            r_pend_level <= w_pend_level_next;
            r_pin        <= w_pin_next;
            r_pos        <= w_pos_next;
            r_neg        <= w_neg_next;
            r_drop       <= w_drop_next;
        end
    end

    assign pin          = r_pin;
    assign busy         = (r_state == StHold);
    assign positiveedge = r_pos;
    assign negativeedge = r_neg;
    assign dropped      = r_drop;

endmodule

// File: tb/tb_output_conditioner.sv
// Scoreboard bench for output_conditioner: a time-based reference model predicts outputs
// per clock edge, and a separate monitor compares them one step after each edge.
module tb_output_conditioner;

    localparam int   HT = 3;
    localparam logic RL = 1'b0;

    logic clk = 1'b0;
    logic reset, raise, lower;
    logic pin, busy, positiveedge, negativeedge, dropped;

    output_conditioner #(
        .counterwidth(3),
        .holdtime    (HT),
        .resetlevel  (RL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .raise       (raise),
        .lower       (lower),
        .pin         (pin),
        .busy        (busy),
        .positiveedge(positiveedge),
        .negativeedge(negativeedge),
        .dropped     (dropped)
    );

    always #5 clk = ~clk;

    // Expected vector packing: {pin, busy, positiveedge, negativeedge, dropped}
    logic [4:0] sb_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: edge index, edge of last pin change, pin, one-deep pending request.
    int   m_k;
    int   m_last;
    logic m_pin;
    bit   m_pv;
    logic m_pl;

    task automatic model_reset();
        m_k    = 0;
        m_last = -1000;
        m_pin  = RL;
        m_pv   = 0;
        m_pl   = 1'b0;
    endtask

    // Outputs seen after the next clock edge, given this cycle's requests.
    task automatic model_edge(input logic r, input logic l, output logic [4:0] e);
        logic drop, req, t, bsy, pos, neg, effv, effl;
        m_k++;
        drop = r & l;
        req  = r ^ l;
        t    = r;
        pos  = 1'b0;
        neg  = 1'b0;
        if (m_k - m_last < HT) begin
            // Inside the minimum-hold window: only remember the latest request.
            bsy = 1'b1;
            if (req) begin
                if (m_pv && m_pl != t) drop = 1'b1;
                m_pv = 1;
                m_pl = t;
            end
        end else begin
            effv = req | m_pv;
            effl = req ? t : m_pl;
            if (req && m_pv && m_pl != t) drop = 1'b1;
            m_pv = 0;
            if (effv && effl != m_pin) begin
                m_pin  = effl;
                m_last = m_k;
                pos    = effl;
                neg    = ~effl;
                bsy    = 1'b1;
            end else begin
                bsy = 1'b0;
            end
        end
        e = {m_pin, bsy, pos, neg, drop};
    endtask

    task automatic step(input logic r, input logic l);
        logic [4:0] e;
        @(negedge clk);
        raise = r;
        lower = l;
        model_edge(r, l, e);
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] req);
        n_checks++;
        if (got === req) n_pass++;
        else $display("FAIL %s at t=%0t got pin/busy/pos/neg/drop=%b required=%b",
                      name, $time, got, req);
    endtask

    // Async reset asserted mid-cycle; outputs must clear without waiting for a clock.
    task automatic reset_mid();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_immediate", {pin, busy, positiveedge, negativeedge, dropped},
              {RL, 4'b0000});
        sb_q.delete();
        model_reset();
        raise = 1'b0;
        lower = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(posedge clk) begin
        logic [4:0] e;
        #1;
        if (!reset && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("cycle_outputs", {pin, busy, positiveedge, negativeedge, dropped}, e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        raise = 1'b0;
        lower = 1'b0;
        model_reset();
        #1;
        check("reset_hold", {pin, busy, positiveedge, negativeedge, dropped}, {RL, 4'b0000});
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        idle(2);
        // Single raise, then back low
        step(1'b1, 1'b0); idle(5);
        step(1'b0, 1'b1); idle(5);
        // Pending request: raise then lower the next cycle
        step(1'b1, 1'b0); step(1'b0, 1'b1); idle(7);
        // Conflict
        step(1'b1, 1'b1); idle(3);
        // Overwrite of a pending lower by a raise on the expiry edge
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b1, 1'b0); idle(3);
        // Redundant raise while steady high
        step(1'b1, 1'b0); idle(3);
        // Conflict inside the hold window
        step(1'b0, 1'b1); step(1'b1, 1'b1); idle(4);
        // Reset mid-hold with a lower pending
        step(1'b1, 1'b0); step(1'b0, 1'b1);
        reset_mid();
        idle(6);

        for (int i = 0; i < 400; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 9);
            if (sel < 2) step(1'b1, 1'b0);
            else if (sel < 4) step(1'b0, 1'b1);
            else if (sel == 4) step(1'b1, 1'b1);
            else step(1'b0, 1'b0);
            if (i == 200) begin
                reset_mid();
            end
        end
        idle(2);
        @(negedge clk);
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain got %0d entries required 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
